// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word over req/gnt + rvalid, registers it and
// slices out decode fields; the next PC is chosen at retire from control's select.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc_out,
  input  logic        instr_retire,
  input  logic [1:0]  PC_genrator_sel,
  input  logic [31:0] imm_offset,
  input  logic [31:0] rs1_value,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RESP,
    ISSUE,
    FAULT
  } state_e;

  localparam logic [31:0] NopInstr    = 32'h0000_0013;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  localparam bit          TimeoutOn   = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] waitCnt_q, waitCnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] nextPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NopInstr;
      waitCnt_q <= 16'd0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      waitCnt_q <= waitCnt_d;
      cause_q   <= cause_d;
    end
  end

  // Candidate PC for the instruction being retired; all sums wrap modulo 2^32.
  always_comb begin
    nextPc = pc_q + 32'd4;
    case (PC_genrator_sel)
      2'b00:   nextPc = pc_q + 32'd4;
      2'b01:   nextPc = pc_q + imm_offset;
      2'b10:   nextPc = (rs1_value + imm_offset) & ~32'h1;
      default: nextPc = pc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    waitCnt_d = waitCnt_q;
    cause_d   = cause_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_gnt) begin
          state_d   = WAIT_RESP;
          waitCnt_d = 16'd0;
        end
      end
      WAIT_RESP: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end else if (TimeoutOn && (waitCnt_q == TimeoutLast)) begin
          state_d = FAULT;
          cause_d = 2'b10;
        end else begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end
      ISSUE: begin
        if (instr_retire) begin
          // A misaligned target leaves the PC on the offending instruction for debug.
          if (nextPc[1:0] != 2'b00) begin
            state_d = FAULT;
            cause_d = 2'b01;
          end else begin
            pc_d    = nextPc;
            state_d = FETCH;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign fault       = (state_q == FAULT);
  assign fault_cause = cause_q;

  assign instr  = instr_q;
  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign func3  = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign func7  = instr_q[31:25];

endmodule
